// File: rtl/char_pkg.sv
// Shared constants, character codes and FSM state type for the character blitter.
package char_pkg;

   localparam int CHAR_W     = 8;
   localparam int CHAR_H     = 10;
   localparam int SCREEN_W   = 160;
   localparam int SCREEN_H   = 120;
   localparam int COL_W      = 3;
   localparam int ROW_W      = 4;
   localparam int GLYPH_BITS = CHAR_W * CHAR_H;

   localparam logic [5:0] BG_COLOUR = 6'b000000;

   localparam logic [5:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3;
   localparam logic [5:0] CH_4 = 6'd4,  CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7;
   localparam logic [5:0] CH_8 = 6'd8,  CH_9 = 6'd9;
   localparam logic [5:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13;
   localparam logic [5:0] CH_E = 6'd14, CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17;
   localparam logic [5:0] CH_I = 6'd18, CH_J = 6'd19, CH_K = 6'd20, CH_L = 6'd21;
   localparam logic [5:0] CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25;
   localparam logic [5:0] CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
   localparam logic [5:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33;
   localparam logic [5:0] CH_Y = 6'd34, CH_Z = 6'd35;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } blit_state_t;

endpackage

// File: rtl/char_glyph_rom.sv
// Combinational glyph ROM: (code, col, row) -> lit bit for the 8x10 character cell.
module char_glyph_rom
   import char_pkg::*;
(
   input  logic [5:0]       code,
   input  logic [COL_W-1:0] col,
   input  logic [ROW_W-1:0] row,
   output logic             lit
);

   // Each glyph is ten row bytes, row 0 first; within a byte the MSB is col 0.
   logic [GLYPH_BITS-1:0] bits;
   logic [GLYPH_BITS-1:0] shifted;
   logic [6:0]            bit_idx;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      bits    = '0;
      shifted = '0;
      bit_idx = 7'(GLYPH_BITS - 1) - 7'(col);
      case (code)
         CH_0: bits = 80'h1E_21_23_25_29_31_21_21_21_1E;
         CH_1: bits = 80'h0C_1C_0C_0C_0C_0C_0C_0C_0C_3F;
         CH_2: bits = 80'h1E_21_01_01_02_04_08_10_20_3F;
         CH_3: bits = 80'h1E_21_01_01_0E_01_01_01_21_1E;
         CH_4: bits = 80'h02_06_0A_12_22_3F_02_02_02_02;
         CH_5: bits = 80'h3F_20_20_20_3E_01_01_01_21_1E;
         CH_6: bits = 80'h1E_21_20_20_3E_21_21_21_21_1E;
         CH_7: bits = 80'h3F_01_01_02_04_08_08_08_08_08;
         CH_8: bits = 80'h1E_21_21_21_1E_21_21_21_21_1E;
         CH_9: bits = 80'h1E_21_21_21_1F_01_01_01_21_1E;
         CH_A: bits = 80'h0C_12_21_21_21_3F_21_21_21_21;
         CH_B: bits = 80'h3E_21_21_21_3E_21_21_21_21_3E;
         CH_C: bits = 80'h1E_21_20_20_20_20_20_20_21_1E;
         CH_D: bits = 80'h3E_21_21_21_21_21_21_21_21_3E;
         CH_E: bits = 80'h3F_20_20_20_3F_20_20_20_20_3F;
         CH_F: bits = 80'h3F_20_20_20_3E_20_20_20_20_20;
         CH_G: bits = 80'h1E_21_20_20_27_21_21_21_21_1E;
         CH_H: bits = 80'h21_21_21_21_3F_21_21_21_21_21;
         CH_I: bits = 80'h1E_0C_0C_0C_0C_0C_0C_0C_0C_1E;
         CH_J: bits = 80'h0F_02_02_02_02_02_02_22_22_1C;
         CH_K: bits = 80'h21_22_24_28_30_28_24_22_21_21;
         CH_L: bits = 80'h20_20_20_20_20_20_20_20_20_3F;
         CH_M: bits = 80'h21_33_2D_21_21_21_21_21_21_21;
         CH_N: bits = 80'h21_31_29_25_23_21_21_21_21_21;
         CH_O: bits = 80'h1E_21_21_21_21_21_21_21_21_1E;
         CH_P: bits = 80'h3E_21_21_21_3E_20_20_20_20_20;
         CH_Q: bits = 80'h1E_21_21_21_21_21_25_23_21_1F;
         CH_R: bits = 80'h3E_21_21_21_3E_28_24_22_21_21;
         CH_S: bits = 80'h1E_21_20_20_1E_01_01_01_21_1E;
         CH_T: bits = 80'h3F_0C_0C_0C_0C_0C_0C_0C_0C_0C;
         CH_U: bits = 80'h21_21_21_21_21_21_21_21_21_1E;
         CH_V: bits = 80'h21_21_21_21_21_21_12_12_0C_0C;
         CH_W: bits = 80'h21_21_21_21_21_21_2D_2D_33_21;
         CH_X: bits = 80'h21_21_12_12_0C_0C_12_12_21_21;
         CH_Y: bits = 80'h21_21_12_12_0C_0C_0C_0C_0C_0C;
         CH_Z: bits = 80'h3F_01_02_02_04_08_10_10_20_3F;
         default: bits = '0;
      endcase
      shifted = bits << {row, 3'b000};
      lit     = shifted[bit_idx];
   end

endmodule

// File: rtl/char_blitter.sv
// Character blitter: sweeps an 8x10 cell and strobes clipped glyph pixels to the plot port.
// Build option CHAR_BG_FILL_EN also plots unlit on-screen pixels in the background colour.
module char_blitter #(
   parameter int CHAR_W   = char_pkg::CHAR_W,
   parameter int CHAR_H   = char_pkg::CHAR_H,
   parameter int SCREEN_W = char_pkg::SCREEN_W,
   parameter int SCREEN_H = char_pkg::SCREEN_H
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [5:0] req_code,
   input  logic [7:0] req_x,
   input  logic [7:0] req_y,
   input  logic [5:0] req_colour,
   output logic       plot,
   output logic [7:0] plot_x,
   output logic [7:0] plot_y,
   output logic [5:0] plot_colour,
   output logic       done
);

   import char_pkg::*;

   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(CHAR_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(CHAR_H - 1);
   localparam logic [8:0]       SCREEN_W9 = 9'(SCREEN_W);
   localparam logic [8:0]       SCREEN_H9 = 9'(SCREEN_H);

   blit_state_t      state;
   logic [5:0]       code_r;
   logic [5:0]       colour_r;
   logic [7:0]       x_r;
   logic [7:0]       y_r;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   logic       lit;
   logic       on_screen;
   logic       emit;
   logic [8:0] ax;
   logic [8:0] ay;
   logic [5:0] pix_colour;

   char_glyph_rom u_rom (
      .code (code_r),
      .col  (col),
      .row  (row),
      .lit  (lit)
   );

   // 9-bit sums so a cell hanging past the right or bottom edge clips instead of wrapping.
   assign ax        = {1'b0, x_r} + 9'(col);
   assign ay        = {1'b0, y_r} + 9'(row);
   assign on_screen = (ax < SCREEN_W9) && (ay < SCREEN_H9);

`ifdef CHAR_BG_FILL_EN
   assign emit       = on_screen;
   assign pix_colour = lit ? colour_r : BG_COLOUR;
`else
   assign emit       = on_screen && lit;
   assign pix_colour = colour_r;
`endif

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         code_r      <= '0;
         colour_r    <= '0;
         x_r         <= '0;
         y_r         <= '0;
         col         <= '0;
         row         <= '0;
         req_ready   <= 1'b1;
         plot        <= 1'b0;
         plot_x      <= '0;
         plot_y      <= '0;
         plot_colour <= BG_COLOUR;
         done        <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  code_r    <= req_code;
                  colour_r  <= req_colour;
                  x_r       <= req_x;
                  y_r       <= req_y;
                  col       <= '0;
                  row       <= '0;
                  req_ready <= 1'b0;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               plot <= emit;
               if (emit) begin
                  plot_x      <= ax[7:0];
                  plot_y      <= ay[7:0];
                  plot_colour <= pix_colour;
               end
               if (col == COL_LAST) begin
                  col <= '0;
                  if (row == ROW_LAST) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     row <= row + 1'b1;
                  end
               end else begin
                  col <= col + 1'b1;
               end
            end
            S_DONE: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
